// File: rtl/uart_tx_controller_if.sv
// uart_tx_controller_if
//   Byte-side handshake and serial-line bundle for uart_tx_controller.
//   master modport: the producer (drives Data_Valid/P_Data/Par_En/Par_Typ,
//                   observes Ready/Busy/TX_OUT).
//   slave modport:  the transmitter itself.
//   Signals:
//     Data_Valid  producer offers P_Data this cycle
//     P_Data      byte to transmit (DATA_WIDTH bits)
//     Par_En      1 = append a parity bit to this byte
//     Par_Typ     0 = even parity, 1 = odd parity
//     Ready       holding register empty; transfer on Data_Valid && Ready
//     Busy        a frame is on the line
//     TX_OUT      serial line, idle high
interface uart_tx_controller_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  Data_Valid;
  logic [DATA_WIDTH-1:0] P_Data;
  logic                  Par_En;
  logic                  Par_Typ;
  logic                  Ready;
  logic                  Busy;
  logic                  TX_OUT;

  modport master (
    output Data_Valid, P_Data, Par_En, Par_Typ,
    input  Ready, Busy, TX_OUT
  );

  modport slave (
    input  Data_Valid, P_Data, Par_En, Par_Typ,
    output Ready, Busy, TX_OUT
  );
endinterface

// File: rtl/uart_tx_controller.sv
// uart_tx_controller
//   Baud-paced UART frame sequencer. Accepts bytes on a valid/ready handshake,
//   keeps one byte in a holding register while a frame is on the line, and
//   sends start bit, LSB-first data, optional parity and a stop bit.
//   Parameters:
//     DATA_WIDTH    data bits per frame (>= 1)
//     CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//   Ports:
//     CLK   system clock, rising edge
//     RST   synchronous reset, active low
//     bus   uart_tx_controller_if.slave (Data_Valid, P_Data, Par_En, Par_Typ,
//           Ready, Busy, TX_OUT)
//   Configuration:
//     UART_TX_PARITY_EN  when defined, the PARITY state and parity generator
//                        are built and Par_En/Par_Typ are honoured; otherwise
//                        both inputs are ignored and frames never carry parity.
module uart_tx_controller #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input logic                 CLK,
  input logic                 RST,
  uart_tx_controller_if.slave bus
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST      = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         prescale_q, prescale_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_full_q, hold_full_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  accept;
  logic                  bit_end;

`ifdef UART_TX_PARITY_EN
  // Parity is resolved to a single line value when the byte is captured,
  // so the shift register can be consumed freely during DATA.
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
  logic hold_par_en_q, hold_par_en_d;
  logic hold_par_bit_q, hold_par_bit_d;
`else
  logic unused_par;
  assign unused_par = bus.Par_En ^ bus.Par_Typ;
`endif

  assign accept  = bus.Data_Valid && !hold_full_q;
  assign bit_end = (prescale_q == PRESCALE_LAST);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      prescale_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q       <= 1'b0;
      par_bit_q      <= 1'b0;
      hold_par_en_q  <= 1'b0;
      hold_par_bit_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      prescale_q  <= prescale_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q       <= par_en_d;
      par_bit_q      <= par_bit_d;
      hold_par_en_q  <= hold_par_en_d;
      hold_par_bit_q <= hold_par_bit_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    prescale_d  = '0;
    tx_d        = 1'b1;
    busy_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d       = par_en_q;
    par_bit_d      = par_bit_q;
    hold_par_en_d  = hold_par_en_q;
    hold_par_bit_d = hold_par_bit_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d   = bus.P_Data;
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          par_en_d  = bus.Par_En;
          par_bit_d = (^bus.P_Data) ^ bus.Par_Typ;
`endif
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // A buffered byte takes priority over a fresh offer; either way the
        // next START follows this STOP with no idle cycle in between.
        if (bit_end) begin
          if (hold_full_q) begin
            shift_d     = hold_data_q;
            bit_cnt_d   = '0;
            hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_d    = hold_par_en_q;
            par_bit_d   = hold_par_bit_q;
`endif
            state_d     = START;
          end else if (accept) begin
            shift_d   = bus.P_Data;
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            par_en_d  = bus.Par_En;
            par_bit_d = (^bus.P_Data) ^ bus.Par_Typ;
`endif
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Offers taken while a frame is running park in the holding register,
    // except at the STOP bit end where they were loaded straight in above.
    if (accept && (state_q != IDLE) && !((state_q == STOP) && bit_end)) begin
      hold_data_d = bus.P_Data;
      hold_full_d = 1'b1;
`ifdef UART_TX_PARITY_EN
      hold_par_en_d  = bus.Par_En;
      hold_par_bit_d = (^bus.P_Data) ^ bus.Par_Typ;
`endif
    end

    if ((state_q != IDLE) && !bit_end) begin
      prescale_d = prescale_q + PW'(1);
    end

    // Outputs are computed from the next state so the registered line
    // value lines up with the state it belongs to.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_bit_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;
  assign bus.Ready  = !hold_full_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller
//   Scoreboard bench for uart_tx_controller (DATA_WIDTH=8, CLKS_PER_BIT=4).
//   The driver decides acceptance from a frame-schedule model and pushes the
//   expected frame (start cycle and bit list); a negedge monitor pops frames
//   as they appear on the line and checks every cycle of TX_OUT, Busy and
//   Ready. Parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_controller;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  typedef struct {
    int            start;
    int            len;
    logic [DW+2:0] bits;
  } frame_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  uart_tx_controller_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_controller #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int     checks = 0;
  int     errors = 0;
  frame_t sb[$];
  int     last_start = -1000;
  int     last_end   = -1000;
  bit     flush_req  = 1'b0;
  bit     mon_on     = 1'b0;
  bit     in_frame   = 1'b0;
  bit     rogue      = 1'b0;
  int     pos        = 0;
  frame_t cur;

  task automatic check_output(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One-cycle offer. Acceptance and frame timing come from the schedule:
  // the line is free after the previous frame's last cycle, and only one
  // byte may wait for it.
  task automatic apply_stimulus(input logic [DW-1:0] d, input bit en, input bit typ);
    frame_t f;
    bit     acc;
    bit     p;
    int     n;
    bus.Data_Valid = 1'b1;
    bus.P_Data     = d;
    bus.Par_En     = en;
    bus.Par_Typ    = typ;
    acc = !(last_start > cyc);
    @(posedge CLK);
    #1;
    bus.Data_Valid = 1'b0;
    bus.P_Data     = DW'($urandom);
    bus.Par_En     = 1'($urandom);
    bus.Par_Typ    = 1'($urandom);
    if (acc) begin
      n       = cyc;
      f.start = (n > last_end) ? n : last_end + 1;
      p       = PAR_BUILT && en;
      f.len   = DW + 2 + (p ? 1 : 0);
      f.bits  = '0;
      for (int i = 0; i < DW; i++) f.bits[1+i] = d[i];
      if (p) f.bits[DW+1] = (($countones(d) % 2) == 1) ^ typ;
      f.bits[f.len-1] = 1'b1;
      sb.push_back(f);
      last_start = f.start;
      last_end   = f.start + f.len * CPB - 1;
    end
  endtask

  task automatic do_reset();
    bus.Data_Valid = 1'b0;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    sb.delete();
    last_start = -1000;
    last_end   = -1000;
    flush_req  = 1'b1;
    mon_on     = 1'b1;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (cyc <= last_end && guard < 5000) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    check_int("wait_bound", int'(guard < 5000), 1);
    idle_cycles(2);
  endtask

  always @(negedge CLK) begin
    logic ready_exp;
    if (flush_req) begin
      check_output("reset_tx", bus.TX_OUT, 1'b1);
      check_output("reset_busy", bus.Busy, 1'b0);
      check_output("reset_ready", bus.Ready, 1'b1);
      in_frame  = 1'b0;
      rogue     = 1'b0;
      flush_req = 1'b0;
    end else if (mon_on) begin
      ready_exp = 1'b1;
      foreach (sb[i]) if (sb[i].start > cyc) ready_exp = 1'b0;
      check_output("ready", bus.Ready, ready_exp);
      if (!in_frame && (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0)) begin
        if (sb.size() == 0) begin
          if (!rogue) check_int("frame_expected", sb.size(), 1);
          rogue = 1'b1;
        end else begin
          cur = sb.pop_front();
          check_int("frame_start", cyc, cur.start);
          in_frame = 1'b1;
          pos      = 0;
        end
      end else if (!in_frame) begin
        rogue = 1'b0;
        check_int("late_start", int'(sb.size() > 0 && sb[0].start <= cyc), 0);
      end
      if (in_frame) begin
        check_output("tx_bit", bus.TX_OUT, cur.bits[pos / CPB]);
        check_output("busy", bus.Busy, 1'b1);
        pos++;
        if (pos == cur.len * CPB) in_frame = 1'b0;
      end
    end
  end

  initial begin
    int s;
    bus.Data_Valid = 1'b0;
    bus.P_Data     = '0;
    bus.Par_En     = 1'b0;
    bus.Par_Typ    = 1'b0;
    do_reset();
    idle_cycles(3);

    $display("[TB] single frames: even, odd, no parity");
    apply_stimulus(8'hA5, 1'b1, 1'b0);
    wait_idle();
    apply_stimulus(8'hA5, 1'b1, 1'b1);
    wait_idle();
    apply_stimulus(8'hA5, 1'b0, 1'b0);
    wait_idle();

    $display("[TB] back-to-back with an ignored offer");
    apply_stimulus(8'h3C, 1'b1, 1'b0);
    idle_cycles(4);
    apply_stimulus(8'hFF, 1'b1, 1'b0);
    idle_cycles(3);
    apply_stimulus(8'h00, 1'b0, 1'b0);
    wait_idle();

    $display("[TB] reset during data bit 3");
    apply_stimulus(8'h3C, 1'b1, 1'b0);
    s = last_start;
    idle_cycles(2);
    apply_stimulus(8'h55, 1'b1, 1'b0);
    idle_cycles(s + 4 * CPB + 1 - cyc);
    do_reset();
    idle_cycles(2);
    apply_stimulus(8'hC3, 1'b1, 1'b1);
    wait_idle();

    $display("[TB] random offers");
    for (int k = 0; k < 40; k++) begin
      idle_cycles($urandom_range(0, 20));
      apply_stimulus(DW'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_idle();
    idle_cycles(3);

    check_int("queue_drained", sb.size(), 0);
    check_int("frame_closed", int'(in_frame), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
